pwm_peripheral: RTL and testbench

- Consumes the five control registers written over SPI (output enables, PWM enables, duty cycle) and drives the 16 chip outputs.
- Each output is off, static high, or a shared PWM waveform at a fixed period.
- Sits directly downstream of the SPI register file.
- Outputs are registered and glitch-free.

---
 rtl/pwm_pkg.sv | 25 ++
 rtl/pwm_peripheral_if.sv | 28 ++
 rtl/pwm_prescaler.sv | 31 +++
 rtl/pwm_peripheral.sv | 132 +++++++++++++
 tb/tb_pwm_peripheral.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the 16-channel PWM output block.
// The PWM counter is 8 bits wide and runs 0..254, so one period is 255 ticks.
package pwm_pkg;

  localparam int PWM_CNT_W           = 8;
  localparam int PWM_PERIOD_TICKS    = 255;
  localparam int PWM_NUM_OUT         = 16;
  localparam int PWM_CLK_DIV_DEFAULT = 13;
  localparam int PWM_PRESC_W         = 16;

  // Last counter value before the wrap back to zero.
  localparam logic [PWM_CNT_W-1:0] PWM_CNT_LAST = 8'(PWM_PERIOD_TICKS - 1);

  // Per-bit output function.
  // A disabled bit is low. An enabled static bit is high. An enabled PWM bit
  // follows the shared waveform.
  function automatic logic [PWM_NUM_OUT-1:0] pwm_out_mask(
    input logic [PWM_NUM_OUT-1:0] en_out,
    input logic [PWM_NUM_OUT-1:0] en_pwm,
    input logic                   pwm_raw
  );
    return en_out & (~en_pwm | {PWM_NUM_OUT{pwm_raw}});
  endfunction

endpackage

// File: rtl/pwm_peripheral_if.sv
// Register-file side of the PWM block: the five control bytes written over SPI.
// The register file drives the bytes through the master modport.
// The PWM peripheral consumes them through the slave modport.
interface pwm_peripheral_if;

  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;

  modport master (
    output en_reg_out_7_0,
    output en_reg_out_15_8,
    output en_reg_pwm_7_0,
    output en_reg_pwm_15_8,
    output pwm_duty_cycle
  );

  modport slave (
    input en_reg_out_7_0,
    input en_reg_out_15_8,
    input en_reg_pwm_7_0,
    input en_reg_pwm_15_8,
    input pwm_duty_cycle
  );

endinterface

// File: rtl/pwm_prescaler.sv
// Reusable clock prescaler.
// It counts 0..CLK_DIV-1 and asserts tick in the last cycle of each count.
// With CLK_DIV = 1, tick is high every cycle.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = PWM_CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [PWM_PRESC_W-1:0] PRESC_LAST = PWM_PRESC_W'(CLK_DIV - 1);

  logic [PWM_PRESC_W-1:0] presc_r;

  // Free-running prescale count with synchronous reset and wrap at CLK_DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= {PWM_PRESC_W{1'b0}};
    end else if (presc_r == PRESC_LAST) begin
      presc_r <= {PWM_PRESC_W{1'b0}};
    end else begin
      presc_r <= presc_r + {{(PWM_PRESC_W-1){1'b0}}, 1'b1};
    end
  end

  assign tick = (presc_r == PRESC_LAST);

endmodule

// File: rtl/pwm_peripheral.sv
// 16-channel PWM / static output driver.
// It sits directly downstream of the SPI register file.
// Each output is off, static high, or the shared PWM waveform.
// Outputs and period_start are registered, so they lag the counter state by one clk.
// Optional build macro: PWM_SYNC_UPDATE_EN.
//   When defined, the duty and enable words are sampled only at the period boundary.
//   This means mid-period writes cannot produce runt or double pulses.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = PWM_CLK_DIV_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  pwm_peripheral_if.slave        regs,
  output logic [PWM_NUM_OUT-1:0] out,
  output logic                   period_start
);

  logic                   tick_s;
  logic                   presc_zero_r;
  logic [PWM_CNT_W-1:0]   cnt_r;
  logic                   boundary_s;
  logic [PWM_NUM_OUT-1:0] en_out_in_s;
  logic [PWM_NUM_OUT-1:0] en_pwm_in_s;
  logic [PWM_NUM_OUT-1:0] en_out_act_s;
  logic [PWM_NUM_OUT-1:0] en_pwm_act_s;
  logic [PWM_CNT_W-1:0]   duty_act_s;
  logic                   pwm_raw_s;
  logic [PWM_NUM_OUT-1:0] next_out_s;
  logic [PWM_NUM_OUT-1:0] out_r;
  logic                   period_start_r;

  pwm_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_s)
  );

  // The prescaler is at zero right after reset, and in every cycle that follows a tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_zero_r <= 1'b1;
    end else begin
      presc_zero_r <= tick_s;
    end
  end

  // Tick counter: advances on tick and wraps from 254 to 0, giving a 255-tick period.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {PWM_CNT_W{1'b0}};
    end else if (tick_s) begin
      if (cnt_r == PWM_CNT_LAST) begin
        cnt_r <= {PWM_CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(PWM_CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign boundary_s  = presc_zero_r && (cnt_r == {PWM_CNT_W{1'b0}});
  assign en_out_in_s = {regs.en_reg_out_15_8, regs.en_reg_out_7_0};
  assign en_pwm_in_s = {regs.en_reg_pwm_15_8, regs.en_reg_pwm_7_0};

`ifdef PWM_SYNC_UPDATE_EN
  logic [PWM_CNT_W-1:0]   duty_sh_r;
  logic [PWM_NUM_OUT-1:0] en_out_sh_r;
  logic [PWM_NUM_OUT-1:0] en_pwm_sh_r;

  // Shadow copies of the control words, refreshed only at the period boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_sh_r   <= {PWM_CNT_W{1'b0}};
      en_out_sh_r <= {PWM_NUM_OUT{1'b0}};
      en_pwm_sh_r <= {PWM_NUM_OUT{1'b0}};
    end else if (boundary_s) begin
      duty_sh_r   <= regs.pwm_duty_cycle;
      en_out_sh_r <= en_out_in_s;
      en_pwm_sh_r <= en_pwm_in_s;
    end else begin
      duty_sh_r   <= duty_sh_r;
      en_out_sh_r <= en_out_sh_r;
      en_pwm_sh_r <= en_pwm_sh_r;
    end
  end

  // Use the values being captured in the boundary cycle itself.
  // This lets the new settings govern tick 0 of the new period.
  always_comb begin
    duty_act_s   = duty_sh_r;
    en_out_act_s = en_out_sh_r;
    en_pwm_act_s = en_pwm_sh_r;
    if (boundary_s) begin
      duty_act_s   = regs.pwm_duty_cycle;
      en_out_act_s = en_out_in_s;
      en_pwm_act_s = en_pwm_in_s;
    end else begin
      duty_act_s   = duty_sh_r;
      en_out_act_s = en_out_sh_r;
      en_pwm_act_s = en_pwm_sh_r;
    end
  end
`else
  assign duty_act_s   = regs.pwm_duty_cycle;
  assign en_out_act_s = en_out_in_s;
  assign en_pwm_act_s = en_pwm_in_s;
`endif

  // The counter never reaches 255, so duty 0xFF is a constant high.
  assign pwm_raw_s  = (cnt_r < duty_act_s);
  assign next_out_s = pwm_out_mask(en_out_act_s, en_pwm_act_s, pwm_raw_s);

  // Registered outputs, so the pins are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r          <= {PWM_NUM_OUT{1'b0}};
      period_start_r <= 1'b0;
    end else begin
      out_r          <= next_out_s;
      period_start_r <= boundary_s;
    end
  end

  assign out          = out_r;
  assign period_start = period_start_r;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral with CLK_DIV = 13.
// The reference model works from elapsed cycles since reset:
//   tick   = (k / 13) % 255
//   period = k % 3315
// Directed tests measure high time and period length against hand-computed constants.
module tb_pwm_peripheral;

  localparam int CD  = 13;
  localparam int PER = CD * 255;

  logic        clk;
  logic        rst;
  logic [15:0] out_w;
  logic        ps_w;

  int n_checks = 0;
  int n_errors = 0;

  pwm_peripheral_if regs_if ();

  pwm_peripheral #(
    .CLK_DIV (CD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .regs         (regs_if.slave),
    .out          (out_w),
    .period_start (ps_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model plus per-cycle compare.
  int          k = 0;
  bit          seen_rst = 1'b0;
  logic [15:0] sh_eo = 16'h0000;
  logic [15:0] sh_ep = 16'h0000;
  logic [7:0]  sh_d  = 8'h00;

  always @(posedge clk) begin
    logic        r;
    logic [15:0] eo, ep, exp_out;
    logic [7:0]  d;
    logic        exp_ps, pwm;
    int          tick_idx;
    r  = rst;
    eo = {regs_if.en_reg_out_15_8, regs_if.en_reg_out_7_0};
    ep = {regs_if.en_reg_pwm_15_8, regs_if.en_reg_pwm_7_0};
    d  = regs_if.pwm_duty_cycle;
    #1;
    exp_out = 16'h0000;
    exp_ps  = 1'b0;
    if (r) begin
      k        = 0;
      sh_eo    = 16'h0000;
      sh_ep    = 16'h0000;
      sh_d     = 8'h00;
      seen_rst = 1'b1;
    end else if (seen_rst) begin
      exp_ps   = ((k % PER) == 0);
      tick_idx = (k / CD) % 255;
`ifdef PWM_SYNC_UPDATE_EN
      if (exp_ps) begin
        sh_eo = eo;
        sh_ep = ep;
        sh_d  = d;
      end
      eo = sh_eo;
      ep = sh_ep;
      d  = sh_d;
`endif
      pwm = (tick_idx < int'(d));
      for (int i = 0; i < 16; i++) begin
        exp_out[i] = eo[i] & (ep[i] ? pwm : 1'b1);
      end
      k++;
    end
    if (seen_rst) begin
      check("cyc_out", {16'h0000, out_w}, {16'h0000, exp_out});
      check("cyc_ps", {31'd0, ps_w}, {31'd0, exp_ps});
    end
  end

  // Stimulus helpers.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_regs(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    regs_if.en_reg_out_7_0  = eo[7:0];
    regs_if.en_reg_out_15_8 = eo[15:8];
    regs_if.en_reg_pwm_7_0  = ep[7:0];
    regs_if.en_reg_pwm_15_8 = ep[15:8];
    regs_if.pwm_duty_cycle  = d;
  endtask

  task automatic wait_ps();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!ps_w && n < 4000);
    if (!ps_w) check("wait_ps_timeout", 32'd0, 32'd1);
  endtask

  int hi[16];
  int per_len;

  // Call this on a sample where period_start is high.
  // It stops on the next period_start sample.
  task automatic measure();
    for (int i = 0; i < 16; i++) hi[i] = 0;
    per_len = 0;
    do begin
      for (int i = 0; i < 16; i++) hi[i] += int'(out_w[i]);
      per_len++;
      step();
    end while (!ps_w && per_len < 5000);
  endtask

  int          sweep_exp[5] = '{0, 13, 1664, 3302, 3315};
  logic [7:0]  sweep_d[5]   = '{8'h00, 8'h01, 8'h80, 8'hFE, 8'hFF};
  logic [15:0] mix_eo, mix_ep;
  int          s, hi0, at_write, ex;

  initial begin
    // 1. Reset with all inputs high.
    rst = 1'b1;
    set_regs(16'hFFFF, 16'hFFFF, 8'hFF);
    repeat (5) begin
      step();
      check("rst_out", {16'h0000, out_w}, 32'h0000_0000);
      check("rst_ps", {31'd0, ps_w}, 32'd0);
    end
    rst = 1'b0;
    step();
    check("first_ps", {31'd0, ps_w}, 32'd1);
    check("first_out", {16'h0000, out_w}, 32'h0000_FFFF);

    // 2. Static outputs over two periods.
    set_regs(16'h00FF, 16'h0000, 8'h40);
    wait_ps();
    repeat (2) begin
      measure();
      check("static_len", per_len, 32'd3315);
      check("static_hi_b0", hi[0], 32'd3315);
      check("static_hi_b7", hi[7], 32'd3315);
      check("static_hi_b8", hi[8], 32'd0);
      check("static_hi_b15", hi[15], 32'd0);
    end

    // 3. Duty sweep.
    for (int j = 0; j < 5; j++) begin
      set_regs(16'hFFFF, 16'hFFFF, sweep_d[j]);
      wait_ps();
      measure();
      check("sweep_len", per_len, 32'd3315);
      check("sweep_hi_b0", hi[0], sweep_exp[j]);
      check("sweep_hi_b15", hi[15], sweep_exp[j]);
    end

    // 4. Mixed enable bits at duty 0x80.
    mix_eo = 16'hA5A5;
    mix_ep = 16'h0F0F;
    set_regs(mix_eo, mix_ep, 8'h80);
    wait_ps();
    measure();
    check("mix_len", per_len, 32'd3315);
    for (int i = 0; i < 16; i++) begin
      ex = !mix_eo[i] ? 0 : (!mix_ep[i] ? 3315 : 1664);
      check("mix_hi", hi[i], ex);
    end

    // 5. Duty change from 0x20 to 0xC0 at tick 100.
    set_regs(16'hFFFF, 16'hFFFF, 8'h20);
    wait_ps();
    s        = 0;
    hi0      = 0;
    at_write = 0;
    do begin
      hi0 += int'(out_w[0]);
      if (s == 1300) at_write = int'(out_w[0]);
      if (s == 1299) regs_if.pwm_duty_cycle = 8'hC0;
      step();
      s++;
    end while (!ps_w && s < 5000);
    check("mid_len", s, 32'd3315);
`ifdef PWM_SYNC_UPDATE_EN
    check("mid_hi", hi0, 32'd416);
    check("mid_at_write", at_write, 32'd0);
`else
    check("mid_hi", hi0, 32'd1612);
    check("mid_at_write", at_write, 32'd1);
`endif
    measure();
    check("mid_next_hi", hi[0], 32'd2496);

    // 6. Reset at tick 150 with duty 0xFF.
    set_regs(16'hFFFF, 16'hFFFF, 8'hFF);
    wait_ps();
    repeat (150 * CD) step();
    check("pre_rst_out", {16'h0000, out_w}, 32'h0000_FFFF);
    rst = 1'b1;
    step();
    check("mid_rst_out", {16'h0000, out_w}, 32'h0000_0000);
    check("mid_rst_ps", {31'd0, ps_w}, 32'd0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_ps", {31'd0, ps_w}, 32'd1);
    check("post_rst_out", {16'h0000, out_w}, 32'h0000_FFFF);
    measure();
    check("post_rst_len", per_len, 32'd3315);

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
